// File: rtl/retirement_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : retirement_packer_pkg
// Purpose : Shared types and constants for the retirement packer: record
//           field widths, per-lane uop entry, shared cause/tval/priv entry,
//           packer FSM state encoding and trap itype codes.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package retirement_packer_pkg;

   localparam int unsigned ITYPE_LEN = 3;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned CAUSE_LEN = 5;
   localparam int unsigned PRIV_LEN  = 2;

   localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
   localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } packer_state_e;

   typedef struct packed {
      logic                 iretire;
      logic                 ilastsize;
      logic [ITYPE_LEN-1:0] itype;
      logic [XLEN-1:0]      iaddr;
   } uop_entry_s;

   typedef struct packed {
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
      logic [PRIV_LEN-1:0]  priv;
   } common_entry_s;

   // Exceptions and interrupts always terminate a bundle.
   function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
      return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/retirement_packer_if.sv
`default_nettype none
// ============================================================================
// Module  : retirement_packer_if
// Purpose : Bundles the single-lane record input, the flush request and the
//           multi-lane bundle output of the retirement packer.
// Ports   : master modport - record source / bundle sink (drives in_valid_i,
//           record fields, flush_i, out_ready_i)
//           slave modport  - the packer (drives in_ready_o, out_valid_o,
//           lane_valid_o, uop_o, common_o, count_o)
// Rev     : 1.0  initial release
// ============================================================================
interface retirement_packer_if #(
   parameter int unsigned NrRetiredInstr = 2
);
   import retirement_packer_pkg::*;

   logic                                   in_valid_i;
   logic                                   in_ready_o;
   logic                                   iretire_i;
   logic                                   ilastsize_i;
   logic [ITYPE_LEN-1:0]                   itype_i;
   logic [XLEN-1:0]                        iaddr_i;
   logic [CAUSE_LEN-1:0]                   cause_i;
   logic [XLEN-1:0]                        tval_i;
   logic [PRIV_LEN-1:0]                    priv_i;
   logic                                   flush_i;
   logic                                   out_valid_o;
   logic                                   out_ready_i;
   logic [NrRetiredInstr-1:0]              lane_valid_o;
   uop_entry_s [NrRetiredInstr-1:0]        uop_o;
   common_entry_s                          common_o;
   logic [$clog2(NrRetiredInstr+1)-1:0]    count_o;

   modport master (
      output in_valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i,
             cause_i, tval_i, priv_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, lane_valid_o, uop_o, common_o, count_o
   );

   modport slave (
      input  in_valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i,
             cause_i, tval_i, priv_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, lane_valid_o, uop_o, common_o, count_o
   );

endinterface
`default_nettype wire

// File: rtl/retirement_packer_timeout.sv
`default_nettype none
// ============================================================================
// Module  : packer_timeout
// Purpose : Idle counter for a partially filled bundle. Counts FILL cycles
//           without an accepted record and flags expiry at TIMEOUT-1.
//           Only built when PACKER_TIMEOUT_EN is defined.
// Ports   : clk_i, rst_i  - clock, synchronous active-high reset
//           fill_i        - packer is in FILL
//           accept_i      - a record is accepted this cycle
//           expired_o     - idle limit reached, close the bundle
// Rev     : 1.0  initial release
// ============================================================================
`ifdef PACKER_TIMEOUT_EN
module packer_timeout #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic fill_i,
   input  logic accept_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired_o = fill_i && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!fill_i || accept_i) begin
         cnt_d = '0;
      end else if (!expired_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/retirement_packer.sv
`default_nettype none
// ============================================================================
// Module  : retirement_packer
// Purpose : Regroups the one-record-per-cycle retirement stream into
//           NrRetiredInstr-wide bundles with per-lane uop fields and one
//           shared cause/tval/priv set.
// Ports   : clk_i  - clock
//           rst_i  - synchronous active-high reset
//           bus    - retirement_packer_if.slave (record in, flush, bundle out)
// Config  : PACKER_TIMEOUT_EN - close an idle partial bundle after TIMEOUT
//           FILL cycles without an accept (packer_timeout sub-module).
// Rev     : 1.0  initial release
// ============================================================================
module retirement_packer
   import retirement_packer_pkg::*;
#(
   parameter int unsigned NrRetiredInstr = 2,
   parameter int unsigned TIMEOUT        = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   retirement_packer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(NrRetiredInstr + 1);

   if (NrRetiredInstr < 2 || TIMEOUT < 1) begin : g_param_check
      $error("retirement_packer: NrRetiredInstr must be >= 2 and TIMEOUT >= 1");
   end

   packer_state_e                   state_q, state_d;
   logic [CNT_W-1:0]                fill_q, fill_d;
   logic [NrRetiredInstr-1:0]       lane_valid_q, lane_valid_d;
   uop_entry_s [NrRetiredInstr-1:0] uop_q, uop_d;
   common_entry_s                   common_q, common_d;

   uop_entry_s    rec_uop;
   common_entry_s rec_common;
   logic          common_mismatch;
   logic          in_ready;
   logic          accept;
   logic          timeout_hit;

   assign rec_uop    = '{iretire: bus.iretire_i, ilastsize: bus.ilastsize_i,
                         itype: bus.itype_i, iaddr: bus.iaddr_i};
   assign rec_common = '{cause: bus.cause_i, tval: bus.tval_i, priv: bus.priv_i};

   // A record whose shared fields differ cannot join the open bundle; it is
   // refused so it can start the next one.
   assign common_mismatch = bus.in_valid_i && (rec_common != common_q);
   assign in_ready = !rst_i && ((state_q == IDLE) ||
                                ((state_q == FILL) && !common_mismatch));
   assign accept   = bus.in_valid_i && in_ready;

`ifdef PACKER_TIMEOUT_EN
   packer_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .fill_i    (state_q == FILL),
      .accept_i  (accept),
      .expired_o (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      fill_d       = fill_q;
      lane_valid_d = lane_valid_q;
      uop_d        = uop_q;
      common_d     = common_q;
      case (state_q)
         IDLE: begin
            // A lone trap record still forms a complete one-lane bundle.
            if (accept) begin
               uop_d[0]        = rec_uop;
               lane_valid_d[0] = 1'b1;
               common_d        = rec_common;
               fill_d          = CNT_W'(1);
               state_d         = is_trap(bus.itype_i) ? HOLD : FILL;
            end
         end
         FILL: begin
            if (accept) begin
               for (int i = 0; i < NrRetiredInstr; i++) begin
                  if (fill_q == CNT_W'(i)) begin
                     uop_d[i]        = rec_uop;
                     lane_valid_d[i] = 1'b1;
                  end
               end
               fill_d = fill_q + CNT_W'(1);
            end
            if (common_mismatch || bus.flush_i || timeout_hit ||
                (accept && (is_trap(bus.itype_i) ||
                            (fill_q == CNT_W'(NrRetiredInstr - 1))))) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready_i) begin
               state_d      = IDLE;
               fill_d       = '0;
               lane_valid_d = '0;
               uop_d        = '0;
               common_d     = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         fill_q       <= '0;
         lane_valid_q <= '0;
         uop_q        <= '0;
         common_q     <= '0;
      end else begin
         state_q      <= state_d;
         fill_q       <= fill_d;
         lane_valid_q <= lane_valid_d;
         uop_q        <= uop_d;
         common_q     <= common_d;
      end
   end

   // Lanes fill contiguously from 0, so the fill level is the lane popcount.
   assign bus.in_ready_o   = in_ready;
   assign bus.out_valid_o  = (state_q == HOLD);
   assign bus.lane_valid_o = lane_valid_q;
   assign bus.uop_o        = uop_q;
   assign bus.common_o     = common_q;
   assign bus.count_o      = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_retirement_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_retirement_packer
// Purpose : Self-checking bench for retirement_packer (N=2, TIMEOUT=8).
//           Expected bundles are queued as records are driven and compared
//           when the packer presents a bundle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_retirement_packer;
   import retirement_packer_pkg::*;

   localparam int unsigned N = 2;

   typedef struct packed {
      uop_entry_s    u;
      common_entry_s c;
   } rec_t;

   typedef struct {
      logic [1:0]       lv;
      logic [1:0]       cnt;
      uop_entry_s [1:0] uop;
      common_entry_s    com;
   } bundle_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   int      checks = 0;
   int      errors = 0;
   bundle_t sb_q[$];
   bundle_t mon_exp;

   retirement_packer_if #(.NrRetiredInstr(N)) bus ();

   retirement_packer #(
      .NrRetiredInstr (N),
      .TIMEOUT        (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic rec_t mk_rec(input logic [31:0] addr, input logic [2:0] itype,
                                   input logic [1:0] priv);
      rec_t r;
      r.u.iretire   = 1'b1;
      r.u.ilastsize = addr[2];
      r.u.itype     = itype;
      r.u.iaddr     = addr;
      r.c.cause     = 5'(priv) + 5'd1;
      r.c.tval      = {24'hCAFE00, 6'd0, priv};
      r.c.priv      = priv;
      return r;
   endfunction

   function automatic bundle_t mk1(input rec_t a);
      bundle_t b;
      b.lv = 2'b01; b.cnt = 2'd1;
      b.uop[0] = a.u; b.uop[1] = '0;
      b.com = a.c;
      return b;
   endfunction

   function automatic bundle_t mk2(input rec_t a, input rec_t r2);
      bundle_t b;
      b.lv = 2'b11; b.cnt = 2'd2;
      b.uop[0] = a.u; b.uop[1] = r2.u;
      b.com = a.c;
      return b;
   endfunction

   // Bundle monitor: handshake completes on the following posedge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid_o && bus.out_ready_i) begin
         check_eq("bundle_expected", 128'(sb_q.size() != 0), 128'(1));
         if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            check_eq("lane_valid", 128'(bus.lane_valid_o), 128'(mon_exp.lv));
            check_eq("count",      128'(bus.count_o),      128'(mon_exp.cnt));
            check_eq("uop",        128'(bus.uop_o),        128'(mon_exp.uop));
            check_eq("common",     128'(bus.common_o),     128'(mon_exp.com));
         end
      end
   end

   task automatic drive_rec(input rec_t r);
      bus.iretire_i   = r.u.iretire;
      bus.ilastsize_i = r.u.ilastsize;
      bus.itype_i     = r.u.itype;
      bus.iaddr_i     = r.u.iaddr;
      bus.cause_i     = r.c.cause;
      bus.tval_i      = r.c.tval;
      bus.priv_i      = r.c.priv;
   endtask

   task automatic wait_accept(output int waits);
      waits = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready_o) break;
         waits++;
         if (waits > 40) begin
            check_eq("accept_timeout", 128'(waits), 128'(0));
            break;
         end
      end
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic send(input rec_t r, output int waits);
      drive_rec(r);
      bus.in_valid_i = 1'b1;
      wait_accept(waits);
   endtask

   task automatic flush_pulse();
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rec_t    a, b, c;
      bundle_t held;
      int      w;
      logic    seen;

      bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
      drive_rec('0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready",   128'(bus.in_ready_o),   128'(0));
      check_eq("rst_out_valid",  128'(bus.out_valid_o),  128'(0));
      check_eq("rst_lane_valid", 128'(bus.lane_valid_o), 128'(0));
      check_eq("rst_count",      128'(bus.count_o),      128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_in_ready", 128'(bus.in_ready_o), 128'(1));
      @(posedge clk); #1;

      // Two back-to-back records fill a bundle
      a = mk_rec(32'h1000, 3'd0, 2'd3);
      b = mk_rec(32'h1004, 3'd0, 2'd3);
      sb_q.push_back(mk2(a, b));
      send(a, w);
      send(b, w);
      check_eq("t1_out_valid_after_b", 128'(bus.out_valid_o), 128'(1));
      check_eq("t1_count",             128'(bus.count_o),     128'(2));

      // Exception closes a bundle; lone interrupt forms a one-lane bundle
      a = mk_rec(32'h2000, 3'd0, 2'd3);
      b = mk_rec(32'h2004, 3'd1, 2'd3);
      c = mk_rec(32'h2100, 3'd2, 2'd3);
      sb_q.push_back(mk2(a, b));
      sb_q.push_back(mk1(c));
      send(a, w);
      send(b, w);
      send(c, w);
      check_eq("t2_int_closes", 128'(bus.out_valid_o), 128'(1));

      // Privilege change: B refused, then starts the next bundle
      a = mk_rec(32'h3000, 3'd0, 2'd3);
      b = mk_rec(32'h3004, 3'd0, 2'd1);
      sb_q.push_back(mk1(a));
      sb_q.push_back(mk1(b));
      send(a, w);
      send(b, w);
      check_eq("t3_holdoff_cycles", 128'(w), 128'(2));
      flush_pulse();

      // Flush closes a partial bundle; flush in IDLE emits nothing
      a = mk_rec(32'h4000, 3'd0, 2'd0);
      sb_q.push_back(mk1(a));
      send(a, w);
      flush_pulse();
      repeat (3) @(posedge clk);
      #1;
      flush_pulse();
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | bus.out_valid_o;
      end
      check_eq("t4_idle_flush_no_bundle", 128'(seen), 128'(0));
      @(posedge clk); #1;

      // Back-pressure: bundle held stable, next record waits
      bus.out_ready_i = 1'b0;
      a = mk_rec(32'h5000, 3'd0, 2'd2);
      b = mk_rec(32'h5004, 3'd0, 2'd2);
      c = mk_rec(32'h5008, 3'd0, 2'd2);
      held = mk2(a, b);
      sb_q.push_back(held);
      sb_q.push_back(mk1(c));
      send(a, w);
      send(b, w);
      drive_rec(c);
      bus.in_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t5_hold_out_valid", 128'(bus.out_valid_o),  128'(1));
         check_eq("t5_hold_in_ready",  128'(bus.in_ready_o),   128'(0));
         check_eq("t5_hold_uop",       128'(bus.uop_o),        128'(held.uop));
         check_eq("t5_hold_lanes",     128'(bus.lane_valid_o), 128'(held.lv));
      end
      @(posedge clk); #1;
      bus.out_ready_i = 1'b1;
      wait_accept(w);
      flush_pulse();
      @(posedge clk); #1;

      // Reset mid-bundle discards it
      a = mk_rec(32'h6000, 3'd0, 2'd3);
      send(a, w);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_fill_out_valid",  128'(bus.out_valid_o),  128'(0));
      check_eq("rst_fill_lane_valid", 128'(bus.lane_valid_o), 128'(0));
      check_eq("rst_fill_count",      128'(bus.count_o),      128'(0));
      check_eq("rst_fill_in_ready",   128'(bus.in_ready_o),   128'(0));
      check_eq("rst_fill_uop",        128'(bus.uop_o),        128'(0));
      check_eq("rst_fill_common",     128'(bus.common_o),     128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Idle partial bundle
      a = mk_rec(32'h7000, 3'd0, 2'd3);
`ifdef PACKER_TIMEOUT_EN
      sb_q.push_back(mk1(a));
      send(a, w);
      w = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         w++;
         if (bus.out_valid_o) break;
      end
      check_eq("t6_timeout_cycles", 128'(w), 128'(8));
`else
      send(a, w);
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         seen = seen | bus.out_valid_o;
      end
      check_eq("t6_no_timeout_close", 128'(seen), 128'(0));
      sb_q.push_back(mk1(a));
      flush_pulse();
`endif

      repeat (4) @(posedge clk);
      check_eq("sb_drained", 128'(sb_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
